// File: rtl/reaction_round_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// reaction_round_ctrl
//
// Multi-round sequencer for the reaction-time game. Runs from the 1 kHz tick
// clock, so one cycle is one millisecond.
//
// Each round does the following:
//   - debounces the start/stop button;
//   - asks the random generator for a value and turns it into a pre-GO delay;
//   - counts that delay down;
//   - times the player's reaction;
//   - catches false starts.
// After NUM_ROUNDS scored rounds it presents a final score.
//
// Build option:
//   AVG_SCORE_EN  defined   : DONE shows the truncated average of all results
//                             (a sum accumulator is built).
//                 undefined : DONE shows the best (lowest) result.
//
// Ports:
//   clk_1khz        1 kHz clock
//   rst             asynchronous, active-high reset
//   btn_i           raw button level, already synchronised to clk_1khz
//   rand_req_o      one-cycle request to the random generator (first ARM cycle)
//   rand_valid_i    random number available (level or pulse), used only in ARM
//   rand_num_i[7:0] random value qualified by rand_valid_i
//   led_set_o       SET indicator (ARM and WAIT)
//   led_go_o        GO indicator
//   disp_value_o    binary value for the display, 0..9999
//   disp_mode_o     0 blank, 1 value, 2 dashes (false start)
//   round_idx_o     current round, 0-based
//   false_start_o   high while the false-start indication is shown
//   done_o          high while the final score is shown
//
// All outputs are registered. They are computed from the next-state values,
// so each output lines up cycle-for-cycle with the state register.
// -----------------------------------------------------------------------------
module reaction_round_ctrl #(
    parameter int unsigned NUM_ROUNDS    = 4,
    parameter int unsigned DEBOUNCE_MS   = 5,
    parameter int unsigned BASE_DELAY_MS = 1000,
    parameter int unsigned DELAY_SCALE   = 8,
    parameter int unsigned SHOW_MS       = 2000,
    parameter int unsigned FAULT_MS      = 1000,
    parameter int unsigned TIMEOUT_MS    = 5000
) (
    input  logic        clk_1khz,
    input  logic        rst,
    input  logic        btn_i,
    output logic        rand_req_o,
    input  logic        rand_valid_i,
    input  logic [7:0]  rand_num_i,
    output logic        led_set_o,
    output logic        led_go_o,
    output logic [13:0] disp_value_o,
    output logic [1:0]  disp_mode_o,
    output logic [2:0]  round_idx_o,
    output logic        false_start_o,
    output logic        done_o
);

    localparam int unsigned DB_W     = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned HOLD_MAX = (SHOW_MS > FAULT_MS) ? SHOW_MS : FAULT_MS;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [DB_W-1:0]   DB_ONE     = DB_W'(1);
    localparam logic [HOLD_W-1:0] SHOW_LAST  = HOLD_W'(SHOW_MS - 1);
    localparam logic [HOLD_W-1:0] FAULT_LAST = HOLD_W'(FAULT_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [13:0]       TIMEOUT_V  = 14'(TIMEOUT_MS);
    localparam logic [13:0]       BEST_INIT  = 14'd9999;
    localparam logic [13:0]       ONE_14     = 14'd1;
    localparam logic [2:0]        LAST_ROUND = 3'(NUM_ROUNDS - 1);
    localparam logic [2:0]        ROUND_ONE  = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WAIT  = 3'd2,
        S_GO    = 3'd3,
        S_SHOW  = 3'd4,
        S_FAULT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Debouncer
    logic [DB_W-1:0]   db_cnt_q;
    logic              btn_db_q;
    logic              btn_db_prev_q;
    logic              press_s;

    // Sequencer state
    state_t            state_q, state_d;
    logic [2:0]        round_q, round_d;
    logic [13:0]       dly_q, dly_d;
    logic [13:0]       tmr_q, tmr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [13:0]       result_q, result_d;
    logic [13:0]       best_q, best_d;
`ifdef AVG_SCORE_EN
    localparam int unsigned RND_SHIFT = $clog2(NUM_ROUNDS);
    logic [16:0]       sum_q, sum_d;
`endif
    logic [13:0]       dly_full_s;
    logic [13:0]       dly_load_s;
    logic [13:0]       score_s;

    // Output registers
    logic              rand_req_q, rand_req_d;
    logic              led_set_q, led_set_d;
    logic              led_go_q, led_go_d;
    logic [13:0]       disp_value_q, disp_value_d;
    logic [1:0]        disp_mode_q, disp_mode_d;
    logic [2:0]        round_idx_q, round_idx_d;
    logic              false_start_q, false_start_d;
    logic              done_q, done_d;

    // Debounce: btn must disagree with btn_db for DEBOUNCE_MS straight cycles before btn_db follows
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
        end else begin
            btn_db_prev_q <= btn_db_q;
            if (btn_i != btn_db_q) begin
                if (db_cnt_q >= DB_LAST) begin
                    btn_db_q <= btn_i;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_ONE;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // Press is only the rising edge of the debounced level; releases are ignored
    assign press_s = btn_db_q & ~btn_db_prev_q;

    // Pre-GO delay is loaded one short because the cycle where dly reaches 0 is itself a WAIT cycle;
    // WAIT therefore lasts exactly BASE_DELAY_MS + rand_num*DELAY_SCALE cycles.
    assign dly_full_s = 14'(BASE_DELAY_MS) + (14'(rand_num_i) * 14'(DELAY_SCALE));
    assign dly_load_s = (dly_full_s == 14'd0) ? 14'd0 : (dly_full_s - ONE_14);

    // State register and datapath registers
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            round_q  <= 3'd0;
            dly_q    <= 14'd0;
            tmr_q    <= 14'd0;
            hold_q   <= '0;
            result_q <= 14'd0;
            best_q   <= 14'd0;
`ifdef AVG_SCORE_EN
            sum_q    <= 17'd0;
`endif
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            dly_q    <= dly_d;
            tmr_q    <= tmr_d;
            hold_q   <= hold_d;
            result_q <= result_d;
            best_q   <= best_d;
`ifdef AVG_SCORE_EN
            sum_q    <= sum_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        dly_d    = dly_q;
        tmr_d    = tmr_q;
        hold_d   = hold_q;
        result_d = result_q;
        best_d   = best_q;
`ifdef AVG_SCORE_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (press_s) begin
                    state_d  = S_ARM;
                    round_d  = 3'd0;
                    result_d = 14'd0;
                    best_d   = BEST_INIT;
`ifdef AVG_SCORE_EN
                    sum_d    = 17'd0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                // A press beats an arriving random number
                if (press_s) begin
                    state_d = S_FAULT;
                    hold_d  = '0;
                end else if (rand_valid_i) begin
                    state_d = S_WAIT;
                    dly_d   = dly_load_s;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_WAIT: begin
                // Press wins even in the final (dly==0) cycle
                if (press_s) begin
                    state_d = S_FAULT;
                    hold_d  = '0;
                end else if (dly_q == 14'd0) begin
                    state_d = S_GO;
                    tmr_d   = 14'd0;
                end else begin
                    dly_d = dly_q - ONE_14;
                end
            end
            S_GO: begin
                if (press_s) begin
                    state_d  = S_SHOW;
                    result_d = tmr_q;
                    hold_d   = '0;
                end else if (tmr_q >= TIMEOUT_V) begin
                    state_d  = S_SHOW;
                    result_d = TIMEOUT_V;
                    hold_d   = '0;
                end else begin
                    tmr_d = tmr_q + ONE_14;
                end
            end
            S_SHOW: begin
                if (hold_q >= SHOW_LAST) begin
                    hold_d = '0;
                    if (round_q >= LAST_ROUND) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ARM;
                        round_d = round_q + ROUND_ONE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            S_FAULT: begin
                // Retry the same round; nothing is scored
                if (hold_q >= FAULT_LAST) begin
                    state_d = S_ARM;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            S_DONE: begin
                if (press_s) begin
                    state_d = S_IDLE;
                    round_d = 3'd0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = 3'd0;
            end
        endcase

        // Score bookkeeping happens once, on the GO->SHOW transition
        if ((state_q == S_GO) && (state_d == S_SHOW)) begin
            best_d = (result_d < best_q) ? result_d : best_q;
`ifdef AVG_SCORE_EN
            sum_d  = sum_q + 17'(result_d);
`endif
        end else begin
            best_d = best_d;
        end
    end

    // Final score shown in DONE
`ifdef AVG_SCORE_EN
    assign score_s = 14'(sum_d >> RND_SHIFT);
`else
    assign score_s = best_d;
`endif

    // Output decode from the state being entered
    always_comb begin
        rand_req_d    = 1'b0;
        led_set_d     = 1'b0;
        led_go_d      = 1'b0;
        disp_value_d  = 14'd0;
        disp_mode_d   = 2'd0;
        round_idx_d   = round_d;
        false_start_d = 1'b0;
        done_d        = 1'b0;
        case (state_d)
            S_IDLE: begin
                round_idx_d = 3'd0;
            end
            S_ARM: begin
                led_set_d  = 1'b1;
                rand_req_d = (state_q != S_ARM);
            end
            S_WAIT: begin
                led_set_d = 1'b1;
            end
            S_GO: begin
                led_go_d     = 1'b1;
                disp_mode_d  = 2'd1;
                disp_value_d = tmr_d;
            end
            S_SHOW: begin
                disp_mode_d  = 2'd1;
                disp_value_d = result_d;
            end
            S_FAULT: begin
                false_start_d = 1'b1;
                disp_mode_d   = 2'd2;
            end
            S_DONE: begin
                done_d       = 1'b1;
                disp_mode_d  = 2'd1;
                disp_value_d = score_s;
            end
            default: begin
                round_idx_d = 3'd0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            rand_req_q    <= 1'b0;
            led_set_q     <= 1'b0;
            led_go_q      <= 1'b0;
            disp_value_q  <= 14'd0;
            disp_mode_q   <= 2'd0;
            round_idx_q   <= 3'd0;
            false_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            rand_req_q    <= rand_req_d;
            led_set_q     <= led_set_d;
            led_go_q      <= led_go_d;
            disp_value_q  <= disp_value_d;
            disp_mode_q   <= disp_mode_d;
            round_idx_q   <= round_idx_d;
            false_start_q <= false_start_d;
            done_q        <= done_d;
        end
    end

    assign rand_req_o    = rand_req_q;
    assign led_set_o     = led_set_q;
    assign led_go_o      = led_go_q;
    assign disp_value_o  = disp_value_q;
    assign disp_mode_o   = disp_mode_q;
    assign round_idx_o   = round_idx_q;
    assign false_start_o = false_start_q;
    assign done_o        = done_q;

endmodule
